// File: rtl/alu_sequencer.sv
// Multi-cycle accumulator sequencer: accepts one instruction, reads its register operand,
// drives an external combinational ALU, then retires it with a one-cycle done pulse.
module alu_sequencer #(
    parameter int REGISTER_WIDTH = 8,
    parameter int OPCODE_WIDTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instrValid,
    output logic                      instrReady,
    input  logic [OPCODE_WIDTH-1:0]   instrOpcode,
    input  logic [2:0]                instrRegAddr,
    output logic [OPCODE_WIDTH-1:0]   aluOpcode,
    output logic [REGISTER_WIDTH-1:0] aluAccumulator,
    output logic [REGISTER_WIDTH-1:0] aluRegisterValue,
    input  logic [REGISTER_WIDTH-1:0] aluResult,
    output logic [REGISTER_WIDTH-1:0] accumulatorOut,
    output logic                      done,
    output logic                      halted
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_INC   = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    state_t                    state_q, state_d;
    logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
    logic [2:0]                addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0] acc_q, acc_d;
    logic [REGISTER_WIDTH-1:0] operand_q, operand_d;
    logic [REGISTER_WIDTH-1:0] alu_acc_hold_q, alu_acc_hold_d;
    logic [REGISTER_WIDTH-1:0] alu_reg_hold_q, alu_reg_hold_d;
    logic [REGISTER_WIDTH-1:0] rf_q [8];
    logic                      rf_we;
    logic                      accept;

    assign accept = instrValid && (state_q == S_IDLE);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        opcode_d       = opcode_q;
        addr_d         = addr_q;
        acc_d          = acc_q;
        operand_d      = operand_q;
        alu_acc_hold_d = alu_acc_hold_q;
        alu_reg_hold_d = alu_reg_hold_q;
        rf_we          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_READ;
                    opcode_d = instrOpcode;
                    addr_d   = instrRegAddr;
                end
            end
            S_READ: begin
                operand_d = rf_q[addr_q];
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Operand outputs keep showing the last executed values once EXECUTE ends.
                alu_acc_hold_d = acc_q;
                alu_reg_hold_d = operand_q;
                case (opcode_q)
                    OP_ADD, OP_OR, OP_INC, OP_AND: acc_d = aluResult;
                    OP_LOAD:                       acc_d = operand_q;
                    OP_STORE:                      rf_we = 1'b1;
                    default:                       ;
                endcase
                state_d = (opcode_q == OP_HALT) ? S_HALTED : S_WRITEBACK;
            end
            S_WRITEBACK: state_d = S_IDLE;
            S_HALTED:    state_d = S_HALTED;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q        <= S_IDLE;
            opcode_q       <= OP_NOP;
            addr_q         <= '0;
            acc_q          <= '0;
            operand_q      <= '0;
            alu_acc_hold_q <= '0;
            alu_reg_hold_q <= '0;
            // NOTE: the register file is only 8 flops deep and must read as zero after reset, so it is cleared here.
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            addr_q         <= addr_d;
            acc_q          <= acc_d;
            operand_q      <= operand_d;
            alu_acc_hold_q <= alu_acc_hold_d;
            alu_reg_hold_q <= alu_reg_hold_d;
            if (rf_we) begin
                rf_q[addr_q] <= acc_q;
            end
        end
    end

    // Status outputs are forced low while reset is asserted, whatever the current state.
    assign instrReady       = !reset && (state_q == S_IDLE);
    assign done             = !reset && (state_q == S_WRITEBACK);
    assign halted           = !reset && (state_q == S_HALTED);
    assign aluOpcode        = (!reset && state_q == S_EXECUTE) ? opcode_q : OP_NOP;
    assign aluAccumulator   = reset ? '0 : (state_q == S_EXECUTE) ? acc_q     : alu_acc_hold_q;
    assign aluRegisterValue = reset ? '0 : (state_q == S_EXECUTE) ? operand_q : alu_reg_hold_q;
    assign accumulatorOut   = acc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the driver queues the expected accumulator per instruction,
// and a monitor pops and compares on every done pulse.
module tb_alu_sequencer;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] ADD   = 4'd2;
    localparam logic [3:0] STORE = 4'd3;
    localparam logic [3:0] UNDEF = 4'd4;
    localparam logic [3:0] OR_OP = 4'd6;
    localparam logic [3:0] INC   = 4'd7;
    localparam logic [3:0] AND_OP = 4'd8;
    localparam logic [3:0] HALT  = 4'd15;

    logic       clock = 1'b0;
    logic       reset;
    logic       instrValid;
    logic       instrReady;
    logic [3:0] instrOpcode;
    logic [2:0] instrRegAddr;
    logic [3:0] aluOpcode;
    logic [7:0] aluAccumulator;
    logic [7:0] aluRegisterValue;
    logic [7:0] aluResult;
    logic [7:0] accumulatorOut;
    logic       done;
    logic       halted;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];
    int         edge_q [$];

    alu_sequencer #(.REGISTER_WIDTH(8), .OPCODE_WIDTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .instrValid       (instrValid),
        .instrReady       (instrReady),
        .instrOpcode      (instrOpcode),
        .instrRegAddr     (instrRegAddr),
        .aluOpcode        (aluOpcode),
        .aluAccumulator   (aluAccumulator),
        .aluRegisterValue (aluRegisterValue),
        .aluResult        (aluResult),
        .accumulatorOut   (accumulatorOut),
        .done             (done),
        .halted           (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference combinational ALU attached to the sequencer.
    always_comb begin
        aluResult = 8'h00;
        case (aluOpcode)
            ADD:    aluResult = aluAccumulator + aluRegisterValue;
            OR_OP:  aluResult = aluAccumulator | aluRegisterValue;
            INC:    aluResult = aluAccumulator + 8'h01;
            AND_OP: aluResult = aluAccumulator & aluRegisterValue;
            default: aluResult = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!instrReady && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (!instrReady) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
        end
    endtask

    // Offer one instruction at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [3:0] op, input logic [2:0] addr,
                         input bit expect_done, input logic [7:0] exp);
        wait_ready();
        instrValid   = 1'b1;
        instrOpcode  = op;
        instrRegAddr = addr;
        if (expect_done) begin
            exp_q.push_back(exp);
            edge_q.push_back(cyc + 1);
        end
        @(negedge clock);
        instrValid   = 1'b0;
        instrOpcode  = ~op;
        instrRegAddr = ~addr;
    endtask

    // Monitor: every done pulse retires the oldest queued expectation.
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                logic [7:0] e;
                int         a;
                e = exp_q.pop_front();
                a = edge_q.pop_front();
                check("acc_on_done", accumulatorOut, e);
                check("done_latency", cyc, a + 2);
                check("alu_nop_in_writeback", aluOpcode, NOP);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] stream_op   [10] = '{INC, HALT, HALT, HALT, INC, HALT, HALT, HALT, ADD, HALT};
    logic [2:0] stream_addr [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};

    initial begin
        logic [7:0] e;
        reset        = 1'b1;
        instrValid   = 1'b0;
        instrOpcode  = NOP;
        instrRegAddr = 3'd0;
        repeat (3) @(negedge clock);

        check("rst_instrReady", instrReady, 0);
        check("rst_done", done, 0);
        check("rst_halted", halted, 0);
        check("rst_aluOpcode", aluOpcode, 0);
        check("rst_aluAccumulator", aluAccumulator, 0);
        check("rst_aluRegisterValue", aluRegisterValue, 0);
        check("rst_accumulatorOut", accumulatorOut, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_instrReady", instrReady, 1);

        issue(INC, 3'd0, 1, 8'h01);

        // Build 0xFF by doubling through r1 and incrementing.
        e = 8'h01;
        for (int k = 0; k < 7; k++) begin
            issue(STORE, 3'd1, 1, e);
            issue(ADD, 3'd1, 1, {e[6:0], 1'b0});
            e = {e[6:0], 1'b1};
            issue(INC, 3'd0, 1, e);
        end
        issue(INC, 3'd0, 1, 8'h00);

        for (int i = 1; i <= 5; i++) issue(INC, 3'd0, 1, 8'(i));
        issue(STORE,  3'd3, 1, 8'h05);
        issue(NOP,    3'd0, 1, 8'h05);
        issue(UNDEF,  3'd2, 1, 8'h05);
        issue(LOAD,   3'd0, 1, 8'h00);
        issue(LOAD,   3'd3, 1, 8'h05);
        issue(ADD,    3'd3, 1, 8'h0A);
        issue(OR_OP,  3'd3, 1, 8'h0F);
        issue(AND_OP, 3'd3, 1, 8'h05);

        // instrValid held high for 10 cycles while the opcode changes every cycle.
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            instrValid   = 1'b1;
            instrOpcode  = stream_op[i];
            instrRegAddr = stream_addr[i];
            check("stream_ready", instrReady, (i % 4) == 0);
            if (i == 0) begin exp_q.push_back(8'h06); edge_q.push_back(cyc + 1); end
            if (i == 4) begin exp_q.push_back(8'h07); edge_q.push_back(cyc + 1); end
            if (i == 8) begin exp_q.push_back(8'h0C); edge_q.push_back(cyc + 1); end
            @(negedge clock);
        end
        instrValid = 1'b0;

        // Reset during EXECUTE of an ADD discards it.
        issue(ADD, 3'd3, 0, 8'h00);
        check("read_alu_nop", aluOpcode, NOP);
        check("read_hold_acc", aluAccumulator, 8'h07);
        check("read_hold_reg", aluRegisterValue, 8'h05);
        @(negedge clock);
        check("exec_aluOpcode", aluOpcode, ADD);
        check("exec_aluAccumulator", aluAccumulator, 8'h0C);
        check("exec_aluRegisterValue", aluRegisterValue, 8'h05);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_acc", accumulatorOut, 8'h00);
        check("midrst_done", done, 0);
        check("midrst_aluOpcode", aluOpcode, 0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_idle_ready", instrReady, 1);
        check("midrst_no_done", done, 0);
        check("midrst_acc_after", accumulatorOut, 8'h00);
        issue(LOAD, 3'd3, 1, 8'h00);

        // HALT stops the block until reset.
        issue(HALT, 3'd0, 0, 8'h00);
        @(negedge clock);
        check("halt_exec_not_halted", halted, 0);
        instrValid  = 1'b1;
        instrOpcode = INC;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("halted_flag", halted, 1);
            check("halted_ready", instrReady, 0);
        end
        instrValid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        check("halt_rst_halted", halted, 0);
        check("halt_rst_ready", instrReady, 0);
        reset = 1'b0;
        @(negedge clock);
        check("halt_cleared", halted, 0);
        check("halt_cleared_ready", instrReady, 1);
        issue(INC, 3'd0, 1, 8'h01);

        repeat (6) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter REGISTER_WIDTH, default 8, width of accumulator, register-file entries and ALU operands.
REQ-002 The block SHALL have parameter OPCODE_WIDTH, default 4, width of instruction and ALU opcode fields.
REQ-003 The block SHALL have a register file of 8 entries, 3-bit address, fixed and not parameterised.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, exposed as the following two ports.
REQ-005 Port clock, input, 1, rising-edge clock for all state.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port instrValid, input, 1, instruction offered.
REQ-008 Port instrReady, output, 1, block accepts an instruction this cycle.
REQ-009 Port instrOpcode, input, OPCODE_WIDTH, instruction opcode.
REQ-010 Port instrRegAddr, input, 3, register-file operand address.
REQ-011 Port aluOpcode, output, OPCODE_WIDTH, opcode driven to the ALU.
REQ-012 Port aluAccumulator, output, REGISTER_WIDTH, accumulator operand to the ALU.
REQ-013 Port aluRegisterValue, output, REGISTER_WIDTH, register operand to the ALU.
REQ-014 Port aluResult, input, REGISTER_WIDTH, combinational ALU result.
REQ-015 Port accumulatorOut, output, REGISTER_WIDTH, current accumulator.
REQ-016 Port done, output, 1, one-cycle pulse on instruction retirement.
REQ-017 Port halted, output, 1, HALT executed, block stopped.

Function
REQ-018 Opcodes SHALL be: NOP=0, LOAD=1, ADD=2, STORE=3, OR=6, INCREMENT=7, AND=8, HALT=15.
REQ-019 All other opcode values SHALL behave as NOP.
REQ-020 FSM states SHALL be IDLE, READ, EXECUTE, WRITEBACK, HALTED.
REQ-021 instrReady SHALL be high only in IDLE.
REQ-022 The handshake SHALL accept an instruction when instrValid && instrReady; opcode and address are captured on that edge, and later input changes are ignored.
REQ-023 The FSM SHALL move IDLE->READ on accept and stay in IDLE otherwise.
REQ-024 In READ, the addressed register-file entry SHALL be latched into an operand register; the state then moves to EXECUTE.
REQ-025 In EXECUTE, aluOpcode SHALL equal the captured opcode, aluAccumulator the accumulator, and aluRegisterValue the operand register.
REQ-026 In all other states, aluOpcode SHALL be NOP and both operand outputs SHALL hold their last values.
REQ-027 On the EXECUTE edge, ADD/OR/INCREMENT/AND SHALL load aluResult into the accumulator verbatim.
REQ-028 On the EXECUTE edge, LOAD SHALL load the operand register into the accumulator.
REQ-029 On the EXECUTE edge, STORE SHALL write the accumulator to the addressed register-file entry.
REQ-030 On the EXECUTE edge, NOP SHALL change nothing.
REQ-031 The FSM SHALL move EXECUTE->WRITEBACK for all opcodes except HALT, which moves EXECUTE->HALTED.
REQ-032 WRITEBACK SHALL assert done for exactly one cycle and return to IDLE.
REQ-033 Latency SHALL be: accept at edge N, done high in the cycle after edge N+2, next accept possible at edge N+4 at the earliest (throughput 1 instruction per 4 cycles).
REQ-034 HALTED SHALL assert halted, keep instrReady low, never pulse done, and be left only by reset.
REQ-035 Arithmetic SHALL wrap modulo 2^REGISTER_WIDTH; the block performs no overflow detection or saturation.
REQ-036 A STORE followed by a LOAD of the same address SHALL return the stored value, with no forwarding hazard because of serial execution.
REQ-037 accumulatorOut SHALL always reflect the accumulator register directly.

Reset
REQ-038 Reset SHALL take priority over all other activity in any state, including mid-instruction; the in-flight instruction is discarded without writing the accumulator or register file.
REQ-039 Reset SHALL return the FSM to IDLE and zero the accumulator, all 8 register-file entries and the operand register.
REQ-040 During reset, done, halted, aluOpcode, aluAccumulator and aluRegisterValue SHALL be 0.
REQ-041 instrReady SHALL be 0 during the reset cycle and 1 on the first cycle after reset deasserts.

Verification
REQ-042 Reset then INCREMENT r0 with the ALU model -> accumulatorOut=0x01, done pulses 3 cycles after accept.
REQ-043 Accumulator 0xFF, INCREMENT -> accumulatorOut=0x00 (wrap).
REQ-044 Accumulator 0x05, STORE r3, NOP, LOAD r0 then LOAD r3 -> 0x00 then 0x05; ADD r3 -> 0x0A.
REQ-045 instrValid held high for 10 cycles with changing opcode -> exactly one accept per 4 cycles, each executes its value captured at accept.
REQ-046 HALT accepted -> halted=1 from the cycle after EXECUTE, instrReady stays 0 and no done pulse; reset then clears halted.
REQ-047 Reset asserted during EXECUTE of ADD -> accumulator=0, no done pulse, FSM in IDLE.
